// File: rtl/mood_pkg.sv
// Shared constants and helpers for the mood counter bank.
package mood_pkg;

  localparam int DEF_N_CH   = 4;
  localparam int DEF_W      = 8;
  localparam int DEF_STEP_W = 4;

  // Which update a channel applies on the current edge, highest priority first.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC,
    ACT_DECAY
  } chan_act_e;

  function automatic int baseline_of(input int w);
    return 1 << (w - 1);
  endfunction

  // One guard bit above the operand width, so an add never wraps before the clamp.
  function automatic int sat_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/mood_counter_bank_if.sv
// Request/status bundle between the stimulus decoders and the mood counter bank.
interface mood_counter_bank_if #(
  parameter int N_CH   = 4,
  parameter int W      = 8,
  parameter int STEP_W = 4
);

  logic [N_CH-1:0]   inc;
  logic [N_CH-1:0]   dec;
  logic [STEP_W-1:0] step;
  logic [N_CH-1:0]   setval;
  logic [W-1:0]      set_value;
  logic              decay_en;
  logic [N_CH*W-1:0] value;
  logic [N_CH-1:0]   at_max;
  logic [N_CH-1:0]   at_min;
  logic              decay_tick;
  logic [N_CH-1:0]   high;

  modport master (
    output inc, dec, step, setval, set_value, decay_en,
    input  value, at_max, at_min, decay_tick, high
  );

  modport slave (
    input  inc, dec, step, setval, set_value, decay_en,
    output value, at_max, at_min, decay_tick, high
  );

endinterface

// File: rtl/mood_channel.sv
// One saturating mood channel: load > inc/dec > decay toward baseline.
// Optional hysteretic high flag when MOOD_COUNTER_HYST_EN is defined.
module mood_channel
  import mood_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int BASELINE = baseline_of(DEF_W)
`ifdef MOOD_COUNTER_HYST_EN
  ,
  parameter int HI_TH    = 192,
  parameter int HYST     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setval,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  input  logic [W-1:0]      set_value,
  input  logic              decay_tick,
  output logic [W-1:0]      value,
  output logic              high
);

  localparam int              SW      = sat_w((W > STEP_W) ? W : STEP_W);
  localparam logic [W-1:0]    BASE    = W'(BASELINE);
  localparam logic [SW-1:0]   MAX_EXT = SW'({W{1'b1}});

  chan_act_e     act;
  logic [SW-1:0] value_ext;
  logic [SW-1:0] step_ext;
  logic [SW-1:0] sum;
  logic [W-1:0]  diff;
  logic [W-1:0]  value_next;

  assign value_ext = SW'(value);
  assign step_ext  = SW'(step);
  assign sum       = value_ext + step_ext;
  assign diff      = value - step_ext[W-1:0];

  // inc and dec together is activity without movement, so it still blocks decay.
  always_comb begin
    act = ACT_HOLD;
    if (setval)
      act = ACT_LOAD;
    else if (inc && !dec)
      act = ACT_INC;
    else if (dec && !inc)
      act = ACT_DEC;
    else if (!inc && !dec && decay_tick)
      act = ACT_DECAY;
  end

  always_comb begin
    value_next = value;
    case (act)
      ACT_LOAD:  value_next = set_value;
      ACT_INC:   value_next = (sum > MAX_EXT) ? {W{1'b1}} : sum[W-1:0];
      ACT_DEC:   value_next = (step_ext > value_ext) ? '0 : diff;
      ACT_DECAY: begin
        if (value > BASE)
          value_next = value - W'(1);
        else if (value < BASE)
          value_next = value + W'(1);
      end
      default:   value_next = value;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      value <= BASE;
    else
      value <= value_next;
  end

`ifdef MOOD_COUNTER_HYST_EN
  localparam logic [W-1:0] HI_SET = W'(HI_TH);
  localparam logic [W-1:0] HI_CLR = W'(HI_TH - HYST);

  // Judged on value_next so the flag moves on the same edge as the value.
  always_ff @(posedge clk) begin
    if (!rst_n)
      high <= 1'b0;
    else if (value_next >= HI_SET)
      high <= 1'b1;
    else if (value_next <= HI_CLR)
      high <= 1'b0;
  end
`else
  assign high = 1'b0;
`endif

endmodule

// File: rtl/mood_counter_bank.sv
// Bank of N_CH decaying saturating mood counters sharing one decay prescaler.
// Define MOOD_COUNTER_HYST_EN to enable the hysteretic high flags.
module mood_counter_bank
  import mood_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int W            = DEF_W,
  parameter int STEP_W       = DEF_STEP_W,
  parameter int DECAY_PERIOD = 16,
  parameter int BASELINE     = baseline_of(W)
`ifdef MOOD_COUNTER_HYST_EN
  ,
  parameter int HI_TH        = 192,
  parameter int HYST         = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mood_counter_bank_if.slave   bus
);

  localparam int            PW       = $clog2(DECAY_PERIOD);
  localparam logic [PW-1:0] PRE_LAST = PW'(DECAY_PERIOD - 1);

  logic [PW-1:0] prescale;

  // Prescaler parks at 0 while decay is disabled so a fresh enable waits a full period.
  always_ff @(posedge clk) begin
    if (!rst_n)
      prescale <= '0;
    else if (!bus.decay_en || prescale == PRE_LAST)
      prescale <= '0;
    else
      prescale <= prescale + PW'(1);
  end

  assign bus.decay_tick = bus.decay_en && (prescale == PRE_LAST);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [W-1:0] ch_value;

    mood_channel #(
      .W        (W),
      .STEP_W   (STEP_W),
      .BASELINE (BASELINE)
`ifdef MOOD_COUNTER_HYST_EN
      ,
      .HI_TH    (HI_TH),
      .HYST     (HYST)
`endif
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .setval     (bus.setval[c]),
      .inc        (bus.inc[c]),
      .dec        (bus.dec[c]),
      .step       (bus.step),
      .set_value  (bus.set_value),
      .decay_tick (bus.decay_tick),
      .value      (ch_value),
      .high       (bus.high[c])
    );

    assign bus.value[c*W +: W] = ch_value;
    assign bus.at_max[c]       = &ch_value;
    assign bus.at_min[c]       = ~|ch_value;
  end

endmodule
